// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous instruction memory; fetch req_*/resp_* handshake, flush, loader ld_*, fault_cnt
module instr_mem_sync #(
    parameter int DATA_W = 32,
    parameter int DEPTH = 1024,
    parameter int ADDR_W = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_inst,
    output logic              resp_fault,
    input  logic              resp_ready,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_index,
    input  logic [DATA_W-1:0] ld_data,
    output logic [15:0]       fault_cnt
);
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: NOP_WORD};
    logic              r_valid;
    logic [DATA_W-1:0] r_inst;
    logic              r_fault;
    logic [15:0]       r_cnt;
    logic [ADDR_W-3:0] w_idx;
    logic              w_fault;
    logic              w_acc;
    assign w_idx = req_addr[ADDR_W-1:2];
    assign w_fault = (req_addr[1:0] != 2'b00) || (64'(w_idx) >= 64'(DEPTH));
    assign req_ready = !r_valid || resp_ready;
    assign w_acc = req_valid && req_ready && !flush && !rst;
    assign resp_valid = r_valid;
    assign resp_inst = r_inst;
    assign resp_fault = r_fault;
    assign fault_cnt = r_cnt;
    always_ff @(posedge clk) begin
        if (ld_en && !rst) r_mem[ld_index] <= ld_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_WORD;
            r_fault <= 1'b0;
            r_cnt   <= 16'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_inst  <= w_fault ? NOP_WORD : r_mem[w_idx[IDX_W-1:0]];
            r_fault <= w_fault;
            if (w_fault && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        end else if (resp_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: table-driven directed checks of instr_mem_sync
module tb_instr_mem_sync;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] A0 = 32'hA000_0000, A2 = 32'hA000_0002, A3 = 32'hA000_0003, B3 = 32'hB000_0003, W1 = 32'h8001_0829;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, resp_valid, resp_fault, resp_ready, flush, ld_en;
    logic [31:0] req_addr, resp_inst, ld_data;
    logic [9:0]  ld_index;
    logic [15:0] fault_cnt;
    int          errors = 0;
    int          checks = 0;
    typedef struct {
        logic        rst;
        logic        ld_en;
        logic [9:0]  ld_index;
        logic [31:0] ld_data;
        logic        req_valid;
        logic [31:0] req_addr;
        logic        resp_ready;
        logic        flush;
        logic        e_ready;
        logic        e_valid;
        logic        ci;
        logic [31:0] e_inst;
        logic        e_fault;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t q[$];
    instr_mem_sync #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .NOP_WORD(NOP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_inst(resp_inst), .resp_fault(resp_fault), .resp_ready(resp_ready),
        .flush(flush), .ld_en(ld_en), .ld_index(ld_index), .ld_data(ld_data), .fault_cnt(fault_cnt)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask
    task automatic add(input logic r, input logic le, input logic [9:0] li, input logic [31:0] ld,
                       input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                       input logic er, input logic ev, input logic ci, input logic [31:0] ei,
                       input logic ef, input logic [15:0] ec);
        q.push_back('{r, le, li, ld, rv, ra, rr, fl, er, ev, ci, ei, ef, ec});
    endtask
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; flush = 1'b0;
        ld_en = 1'b0; ld_index = '0; ld_data = '0;
        @(posedge clk); #1;
        check("rst_valid", -1, 32'(resp_valid), 32'd0);
        check("rst_inst", -1, resp_inst, NOP);
        check("rst_fault", -1, 32'(resp_fault), 32'd0);
        check("rst_cnt", -1, 32'(fault_cnt), 32'd0);
        //  rst le idx  data  rv addr          rr fl  rdy val ci inst fault cnt
        add(0, 1, 10'd1, W1, 0, 32'd0,        1, 0,  1, 0, 1, NOP, 0, 16'd0);
        add(0, 0, 10'd0, 0,  1, 32'd4,        1, 0,  1, 1, 1, W1,  0, 16'd0);
        add(0, 0, 10'd0, 0,  1, 32'd6,        1, 0,  1, 1, 1, NOP, 1, 16'd1);
        add(0, 0, 10'd0, 0,  1, 32'd4096,     1, 0,  1, 1, 1, NOP, 1, 16'd2);
        add(0, 1, 10'd0, A0, 0, 32'd0,        1, 0,  1, 0, 0, 0,   0, 16'd2);
        add(0, 1, 10'd2, A2, 0, 32'd0,        1, 0,  1, 0, 0, 0,   0, 16'd2);
        add(0, 1, 10'd3, A3, 0, 32'd0,        1, 0,  1, 0, 0, 0,   0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd0,        1, 0,  1, 1, 1, A0,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd4,        1, 0,  1, 1, 1, W1,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd8,        1, 0,  1, 1, 1, A2,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd12,       1, 0,  1, 1, 1, A3,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd0,        0, 0,  0, 1, 1, A3,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd0,        0, 0,  0, 1, 1, A3,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd0,        0, 0,  0, 1, 1, A3,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd4,        1, 0,  1, 1, 1, W1,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd8,        1, 1,  1, 0, 0, 0,   0, 16'd2);
        add(0, 1, 10'd3, B3, 1, 32'd12,       1, 0,  1, 1, 1, A3,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd12,       1, 0,  1, 1, 1, B3,  0, 16'd2);
        add(0, 0, 10'd0, 0,  1, 32'd1,        1, 0,  1, 1, 1, NOP, 1, 16'd3);
        add(0, 0, 10'd0, 0,  1, 32'd2,        1, 0,  1, 1, 1, NOP, 1, 16'd4);
        add(0, 0, 10'd0, 0,  1, 32'h1000_0000, 1, 0, 1, 1, 1, NOP, 1, 16'd5);
        add(0, 0, 10'd0, 0,  0, 32'd0,        0, 0,  0, 1, 1, NOP, 1, 16'd5);
        add(1, 1, 10'd1, 32'hDEAD_BEEF, 1, 32'd4, 0, 0, 0, 0, 1, NOP, 0, 16'd0);
        add(0, 0, 10'd0, 0,  1, 32'd4,        1, 0,  1, 1, 1, W1,  0, 16'd0);
        add(0, 0, 10'd0, 0,  0, 32'd0,        1, 0,  1, 0, 0, 0,   0, 16'd0);
        add(0, 0, 10'd0, 0,  1, 32'd8,        0, 0,  1, 1, 1, A2,  0, 16'd0);
        add(0, 0, 10'd0, 0,  0, 32'd0,        0, 1,  0, 0, 0, 0,   0, 16'd0);
        foreach (q[i]) begin
            @(negedge clk);
            rst = q[i].rst; ld_en = q[i].ld_en; ld_index = q[i].ld_index; ld_data = q[i].ld_data;
            req_valid = q[i].req_valid; req_addr = q[i].req_addr; resp_ready = q[i].resp_ready; flush = q[i].flush;
            #1;
            check("req_ready", i, 32'(req_ready), 32'(q[i].e_ready));
            @(posedge clk); #1;
            check("resp_valid", i, 32'(resp_valid), 32'(q[i].e_valid));
            check("fault_cnt", i, 32'(fault_cnt), 32'(q[i].e_cnt));
            if (q[i].ci) begin
                check("resp_inst", i, resp_inst, q[i].e_inst);
                check("resp_fault", i, 32'(resp_fault), 32'(q[i].e_fault));
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
